// File: rtl/axil_reg_slave.sv
// AXI4-Lite register slave: NUM_REGS x 32-bit control registers.
// Independent AW/W capture, one outstanding write, registered R.
module axil_reg_slave #(
  parameter int ADDR_WIDTH = 6,
  parameter int DATA_WIDTH = 32,
  parameter int NUM_REGS   = 8
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           s_awvalid,
  output logic                           s_awready,
  input  logic [ADDR_WIDTH-1:0]          s_awaddr,
  input  logic                           s_wvalid,
  output logic                           s_wready,
  input  logic [DATA_WIDTH-1:0]          s_wdata,
  input  logic [DATA_WIDTH/8-1:0]        s_wstrb,
  output logic                           s_bvalid,
  input  logic                           s_bready,
  output logic [1:0]                     s_bresp,
  input  logic                           s_arvalid,
  output logic                           s_arready,
  input  logic [ADDR_WIDTH-1:0]          s_araddr,
  output logic                           s_rvalid,
  input  logic                           s_rready,
  output logic [DATA_WIDTH-1:0]          s_rdata,
  output logic [1:0]                     s_rresp,
  output logic [NUM_REGS*DATA_WIDTH-1:0] regs_o
);

  localparam int IW = ADDR_WIDTH - 2;
  localparam int SW = DATA_WIDTH / 8;
  localparam int RW = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
  localparam logic [IW-1:0] LAST = IW'(NUM_REGS - 1);
  localparam logic [1:0] OKAY   = 2'b00;
  localparam logic [1:0] SLVERR = 2'b10;

  logic                  aw_held_q;
  logic [IW-1:0]         awidx_q;
  logic                  w_held_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [SW-1:0]         wstrb_q;
  logic                  bvalid_q;
  logic [1:0]            bresp_q;
  logic                  rvalid_q;
  logic [DATA_WIDTH-1:0] rdata_q;
  logic [1:0]            rresp_q;
  logic [DATA_WIDTH-1:0] regs_q [NUM_REGS];

  logic          aw_hs;
  logic          w_hs;
  logic          ar_hs;
  logic          commit;
  logic          aw_ok;
  logic          ar_ok;
  logic [IW-1:0] aridx;
  logic          unused_addr;

  // readies depend on registered state only
  assign s_awready = ~aw_held_q & ~bvalid_q;
  assign s_wready  = ~w_held_q & ~bvalid_q;
  assign s_arready = ~rvalid_q;

  assign aw_hs  = s_awvalid & s_awready;
  assign w_hs   = s_wvalid & s_wready;
  assign ar_hs  = s_arvalid & s_arready;
  assign commit = aw_held_q & w_held_q;

  assign aridx = s_araddr[ADDR_WIDTH-1:2];
  assign aw_ok = (awidx_q <= LAST);
  assign ar_ok = (aridx <= LAST);

  assign unused_addr = ^{s_awaddr[1:0], s_araddr[1:0]};

  assign s_bvalid = bvalid_q;
  assign s_bresp  = bresp_q;
  assign s_rvalid = rvalid_q;
  assign s_rdata  = rdata_q;
  assign s_rresp  = rresp_q;

  // capture AW and W independently; both holds clear on commit
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      aw_held_q <= 1'b0;
      awidx_q   <= '0;
      w_held_q  <= 1'b0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
    end else if (commit) begin
      aw_held_q <= 1'b0;
      w_held_q  <= 1'b0;
    end else begin
      if (aw_hs) begin
        aw_held_q <= 1'b1;
        awidx_q   <= s_awaddr[ADDR_WIDTH-1:2];
      end
      if (w_hs) begin
        w_held_q <= 1'b1;
        wdata_q  <= s_wdata;
        wstrb_q  <= s_wstrb;
      end
    end
  end

  // write response: raised on commit, dropped on B handshake
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bvalid_q <= 1'b0;
      bresp_q  <= OKAY;
    end else if (commit) begin
      bvalid_q <= 1'b1;
      bresp_q  <= aw_ok ? OKAY : SLVERR;
    end else if (bvalid_q && s_bready) begin
      bvalid_q <= 1'b0;
    end
  end

  // register bank with per-byte strobe merge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= '0;
      end
    end else if (commit && aw_ok) begin
      for (int b = 0; b < SW; b++) begin
        if (wstrb_q[b]) begin
          regs_q[awidx_q[RW-1:0]][b*8 +: 8] <= wdata_q[b*8 +: 8];
        end
      end
    end
  end

  // read channel: data registered on AR, held until R handshake
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
      rresp_q  <= OKAY;
    end else if (ar_hs) begin
      rvalid_q <= 1'b1;
      rdata_q  <= ar_ok ? regs_q[aridx[RW-1:0]] : '0;
      rresp_q  <= ar_ok ? OKAY : SLVERR;
    end else if (rvalid_q && s_rready) begin
      rvalid_q <= 1'b0;
    end
  end

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_out
    assign regs_o[g*DATA_WIDTH +: DATA_WIDTH] = regs_q[g];
  end

endmodule
